// File: rtl/line_data_memory.sv
// Line-wide data memory model: one request in flight, fixed access latency.
// Define LINE_DATA_MEMORY_STATS_EN to add saturating read/write counters.
module line_data_memory #(
   parameter int unsigned LINE_WIDTH = 256,
   parameter int unsigned DEPTH      = 512,
   parameter int unsigned LATENCY    = 10,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [LINE_WIDTH-1:0] data_i,
   input  logic                  enable_i,
   input  logic                  write_i,
`ifdef LINE_DATA_MEMORY_STATS_EN
   output logic [31:0]           rd_cnt_o,
   output logic [31:0]           wr_cnt_o,
`endif
   output logic                  ack_o,
   output logic [LINE_WIDTH-1:0] data_o
);

   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] LAST = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] ACK  = 2'd2;

   logic [LINE_WIDTH-1:0] mem [DEPTH];

   logic [1:0]            state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
   logic                  wr_q, wr_d;
   logic                  ack_q, ack_d;
   logic [LINE_WIDTH-1:0] data_q, data_d;

   logic [IW-1:0]         in_idx;
   logic [IW-1:0]         op_idx;
   logic [LINE_WIDTH-1:0] op_data;
   logic                  op_wr;
   logic                  enter_ack;

   assign in_idx = IW'((addr_i >> 5) % DEPTH);

   // With LATENCY=1 the request enters ACK straight from IDLE, so the
   // memory operation must use the live inputs rather than the latches.
   always_comb begin
      op_idx  = idx_q;
      op_data = wdata_q;
      op_wr   = wr_q;
      if (state_q == IDLE) begin
         op_idx  = in_idx;
         op_data = data_i;
         op_wr   = write_i;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      wdata_d   = wdata_q;
      wr_d      = wr_q;
      ack_d     = 1'b0;
      enter_ack = 1'b0;
      case (state_q)
         IDLE: begin
            // ack_q still high marks the mandatory idle gap
            if (enable_i && !ack_q) begin
               idx_d   = in_idx;
               wdata_d = data_i;
               wr_d    = write_i;
               cnt_d   = '0;
               if (LATENCY == 1) begin
                  state_d   = ACK;
                  enter_ack = 1'b1;
               end else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            if (cnt_q == LAST) begin
               state_d   = ACK;
               enter_ack = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ACK: begin
            state_d = IDLE;
            ack_d   = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      data_d = data_q;
      if (enter_ack && !op_wr) begin
         data_d = mem[op_idx];
      end
   end

   always_ff @(posedge clk_i) begin
      if (enter_ack && op_wr) begin
         mem[op_idx] <= op_data;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         ack_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         ack_q   <= ack_d;
         data_q  <= data_d;
      end
   end

   assign ack_o  = ack_q;
   assign data_o = data_q;

`ifdef LINE_DATA_MEMORY_STATS_EN
   logic [31:0] rd_cnt_q, rd_cnt_d;
   logic [31:0] wr_cnt_q, wr_cnt_d;

   always_comb begin
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      if (enter_ack && !op_wr && (rd_cnt_q != 32'hFFFF_FFFF)) begin
         rd_cnt_d = rd_cnt_q + 32'd1;
      end
      if (enter_ack && op_wr && (wr_cnt_q != 32'hFFFF_FFFF)) begin
         wr_cnt_d = wr_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   assign rd_cnt_o = rd_cnt_q;
   assign wr_cnt_o = wr_cnt_q;
`endif

endmodule

// File: tb/tb_line_data_memory.sv
// Bench for line_data_memory: randomized requests against a line-array model.
// Stats checks compile in when LINE_DATA_MEMORY_STATS_EN is defined.
module tb_line_data_memory;

   localparam int L = 10;
   localparam int D = 512;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic [31:0]  addr_i = '0;
   logic [255:0] data_i = '0;
   logic         enable_i = 1'b0;
   logic         write_i = 1'b0;
   logic         ack_o;
   logic [255:0] data_o;
`ifdef LINE_DATA_MEMORY_STATS_EN
   logic [31:0]  rd_cnt_o;
   logic [31:0]  wr_cnt_o;
`endif

   int errs = 0;
   int checks = 0;

   logic [255:0] ref_mem [D];
   bit           valid [D];
   logic [255:0] last_rd = '0;
   int           exp_rd = 0;
   int           exp_wr = 0;

   always #5 clk_i = ~clk_i;

   line_data_memory #(
      .LINE_WIDTH(256),
      .DEPTH(D),
      .LATENCY(L),
      .ADDR_WIDTH(32)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .addr_i(addr_i),
      .data_i(data_i),
      .enable_i(enable_i),
      .write_i(write_i),
`ifdef LINE_DATA_MEMORY_STATS_EN
      .rd_cnt_o(rd_cnt_o),
      .wr_cnt_o(wr_cnt_o),
`endif
      .ack_o(ack_o),
      .data_o(data_o)
   );

   function automatic logic [255:0] rnd_line();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic int line_of(input logic [31:0] a);
      return int'(a[31:5]) % D;
   endfunction

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic model_reset();
      last_rd = '0;
      exp_rd  = 0;
      exp_wr  = 0;
   endtask

   task automatic pulse_reset();
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      model_reset();
   endtask

   // One request; ack must be seen exactly L edges after acceptance.
   task automatic do_req(input bit wr, input logic [31:0] a,
                         input logic [255:0] wd, input string nm);
      int idx;
      logic [255:0] exp_d;
      idx   = line_of(a);
      exp_d = wr ? last_rd : ref_mem[idx];
      enable_i = 1'b1;
      write_i  = wr;
      addr_i   = a;
      data_i   = wd;
      step();
      enable_i = 1'b0;
      write_i  = 1'($urandom);
      addr_i   = $urandom;
      data_i   = rnd_line();
      for (int k = 1; k <= L + 2; k++) begin
         step();
         checks++;
         if (ack_o !== (k == L)) begin
            errs++;
            $display("FAIL %s ack k=%0d got=%b exp=%b", nm, k, ack_o, k == L);
         end
         if (k == L) begin
            checks++;
            if (data_o !== exp_d) begin
               errs++;
               $display("FAIL %s data got=%h exp=%h", nm, data_o, exp_d);
            end
         end
      end
      if (wr) begin
         ref_mem[idx] = wd;
         valid[idx]   = 1'b1;
         exp_wr++;
      end else begin
         last_rd = exp_d;
         exp_rd++;
      end
   endtask

   task automatic test_reset();
      logic [255:0] v;
      checks++;
      if (ack_o !== 1'b0 || data_o !== '0) begin
         errs++;
         $display("FAIL reset_state ack=%b data=%h exp ack=0 data=0", ack_o, data_o);
      end
      v = rnd_line();
      do_req(1'b1, 32'h0000_00A0, v, "rst_pre_wr");
      enable_i = 1'b1;
      write_i  = 1'b0;
      addr_i   = 32'h0000_00A0;
      step();
      enable_i = 1'b0;
      repeat (L) step();
      checks++;
      if (ack_o !== 1'b1 || data_o !== v) begin
         errs++;
         $display("FAIL rst_pre_rd ack=%b data=%h exp ack=1 data=%h", ack_o, data_o, v);
      end
      #2 rst_i = 1'b1;
      #1;
      checks++;
      if (ack_o !== 1'b0 || data_o !== '0) begin
         errs++;
         $display("FAIL async_reset ack=%b data=%h exp ack=0 data=0", ack_o, data_o);
      end
      step();
      rst_i = 1'b0;
      model_reset();
      step();
   endtask

   task automatic test_read_latency();
      do_req(1'b1, 32'h0000_0060, {8{32'hDEADBEEF}}, "preload_l3");
      do_req(1'b0, 32'h0000_0060, '0, "read_latency");
   endtask

   task automatic test_write_read();
      do_req(1'b1, 32'h0000_0400, {8{32'h12345678}}, "wr_400");
      step();
      do_req(1'b0, 32'h0000_0400, '0, "rd_400");
   endtask

   task automatic test_abort();
      do_req(1'b1, 32'h0000_0020, '0, "abort_pre");
      enable_i = 1'b1;
      write_i  = 1'b1;
      addr_i   = 32'h0000_0020;
      data_i   = rnd_line() | 256'h1;
      step();
      enable_i = 1'b0;
      repeat (4) step();
      #3 rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      model_reset();
      for (int k = 1; k <= L + 2; k++) begin
         step();
         checks++;
         if (ack_o !== 1'b0) begin
            errs++;
            $display("FAIL abort_noack k=%0d got=%b exp=0", k, ack_o);
         end
      end
      do_req(1'b0, 32'h0000_0020, '0, "abort_rd");
   endtask

   task automatic test_back_to_back();
      logic [255:0] v;
      logic [255:0] exp_d;
      bit           exp_ack;
      v = rnd_line();
      do_req(1'b1, 32'h0000_4000, v, "wrap_wr");
      exp_d    = ref_mem[line_of(32'h0)];
      enable_i = 1'b1;
      write_i  = 1'b0;
      addr_i   = 32'h0;
      step();
      for (int k = 1; k <= 2 * L + 3; k++) begin
         step();
         exp_ack = (k == L) || (k == 2 * L + 2);
         checks++;
         if (ack_o !== exp_ack) begin
            errs++;
            $display("FAIL hold_ack k=%0d got=%b exp=%b", k, ack_o, exp_ack);
         end
         if (exp_ack) begin
            checks++;
            if (data_o !== exp_d) begin
               errs++;
               $display("FAIL wrap_rd k=%0d got=%h exp=%h", k, data_o, exp_d);
            end
         end
      end
      enable_i = 1'b0;
      exp_rd  += 2;
      last_rd  = exp_d;
      step();
      do_req(1'b1, $urandom, rnd_line(), "hold_data_wr");
   endtask

   task automatic test_random();
      logic [31:0] a;
      for (int n = 0; n < 20; n++) begin
         a = $urandom;
         if (valid[line_of(a)] && ($urandom_range(0, 1) == 1))
            do_req(1'b0, a, '0, "rand_rd");
         else
            do_req(1'b1, a, rnd_line(), "rand_wr");
      end
   endtask

`ifdef LINE_DATA_MEMORY_STATS_EN
   task automatic test_stats();
      pulse_reset();
      do_req(1'b1, 32'h0000_1000, rnd_line(), "st_wr0");
      do_req(1'b0, 32'h0000_1000, '0, "st_rd0");
      do_req(1'b1, 32'h0000_2000, rnd_line(), "st_wr1");
      do_req(1'b0, 32'h0000_2000, '0, "st_rd1");
      do_req(1'b0, 32'h0000_1000, '0, "st_rd2");
      checks++;
      if (rd_cnt_o !== 32'(exp_rd) || wr_cnt_o !== 32'(exp_wr)) begin
         errs++;
         $display("FAIL stats rd=%0d wr=%0d exp rd=%0d wr=%0d",
                  rd_cnt_o, wr_cnt_o, exp_rd, exp_wr);
      end
      pulse_reset();
      checks++;
      if (rd_cnt_o !== 32'd0 || wr_cnt_o !== 32'd0) begin
         errs++;
         $display("FAIL stats_reset rd=%0d wr=%0d exp 0 0", rd_cnt_o, wr_cnt_o);
      end
   endtask
`endif

   initial begin
      rst_i = 1'b1;
      repeat (3) step();
      rst_i = 1'b0;
      step();
      test_reset();
      test_read_latency();
      test_write_read();
      test_abort();
      test_back_to_back();
      test_random();
`ifdef LINE_DATA_MEMORY_STATS_EN
      test_stats();
`endif
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
